alu_mdu: RTL and testbench

ALU_MDU -- requirements
Module: alu_mdu

---
 rtl/alu_mdu_if.sv | 26 ++
 rtl/alu_mdu.sv | 133 +++++++++++++
 tb/tb_alu_mdu.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_if.sv
// Operand, opcode and result bundle between an issuing master and the alu_mdu datapath.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       ALUctr;
    logic [2:0]       MDop;
    logic             start;
    logic [WIDTH-1:0] Output;
    logic             zero;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output A, B, ALUctr, MDop, start,
        input  Output, zero, busy, done, hi, lo
    );

    modport slave (
        input  A, B, ALUctr, MDop, start,
        output Output, zero, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_mdu.sv
// Combinational ALU plus a multi-cycle multiply/divide unit with HI/LO registers.
// Results are computed at issue and held pending until the cycle counter expires.
module alu_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic       clk,
    input logic       reset,
    alu_mdu_if.slave  bus
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi_q, lo_q, pend_hi, pend_lo;
    logic               pend_wr;
    logic [WIDTH-1:0]   alu_out;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, div_q, div_r, divu_q, divu_r;
    logic               a_neg, b_neg;

    always_comb begin
        alu_out = '0;
        case (bus.ALUctr)
            3'd0: alu_out = bus.A + bus.B;
            3'd1: alu_out = bus.A - bus.B;
            3'd2: alu_out = bus.A | bus.B;
            3'd3: alu_out = bus.A & bus.B;
            3'd4: alu_out = bus.A ^ bus.B;
            3'd5: alu_out = ~(bus.A | bus.B);
            3'd6: alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            3'd7: alu_out = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
        endcase
    end

    // Signed divide on magnitudes so most-negative / -1 wraps cleanly instead of overflowing.
    always_comb begin
        prod_s = {{WIDTH{bus.A[WIDTH-1]}}, bus.A} * {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
        prod_u = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
        a_neg  = bus.A[WIDTH-1];
        b_neg  = bus.B[WIDTH-1];
        a_mag  = a_neg ? (WIDTH'(0) - bus.A) : bus.A;
        b_mag  = b_neg ? (WIDTH'(0) - bus.B) : bus.B;
        q_mag  = '0;
        r_mag  = '0;
        divu_q = '0;
        divu_r = '0;
        if (bus.B != '0) begin
            q_mag  = a_mag / b_mag;
            r_mag  = a_mag % b_mag;
            divu_q = bus.A / bus.B;
            divu_r = bus.A % bus.B;
        end
        div_q = (a_neg ^ b_neg) ? (WIDTH'(0) - q_mag) : q_mag;
        div_r = a_neg ? (WIDTH'(0) - r_mag) : r_mag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.MDop)
                            3'd1: begin
                                pend_hi <= prod_s[2*WIDTH-1:WIDTH];
                                pend_lo <= prod_s[WIDTH-1:0];
                                pend_wr <= 1'b1;
                                cnt     <= CW'(MUL_CYCLES);
                                state   <= RUN;
                            end
                            3'd2: begin
                                pend_hi <= prod_u[2*WIDTH-1:WIDTH];
                                pend_lo <= prod_u[WIDTH-1:0];
                                pend_wr <= 1'b1;
                                cnt     <= CW'(MUL_CYCLES);
                                state   <= RUN;
                            end
                            3'd3: begin
                                pend_hi <= div_r;
                                pend_lo <= div_q;
                                pend_wr <= (bus.B != '0);
                                cnt     <= CW'(DIV_CYCLES);
                                state   <= RUN;
                            end
                            3'd4: begin
                                pend_hi <= divu_r;
                                pend_lo <= divu_q;
                                pend_wr <= (bus.B != '0);
                                cnt     <= CW'(DIV_CYCLES);
                                state   <= RUN;
                            end
                            3'd5: hi_q <= bus.A;
                            3'd6: lo_q <= bus.A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt == CW'(1)) begin
                        if (pend_wr) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.Output = alu_out;
    assign bus.zero   = (bus.A == bus.B);
    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == RUN) && (cnt == CW'(1));
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: random ALU/MDU traffic against a plain-arithmetic model.
module tb_alu_mdu;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] m_hi, m_lo;
    logic [15:0] m16_hi, m16_lo;

    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(32)) bus32 ();
    alu_mdu_if #(.WIDTH(16)) bus16 ();

    alu_mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut32 (
        .clk(clk), .reset(reset), .bus(bus32.slave));
    alu_mdu #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(16)) dut16 (
        .clk(clk), .reset(reset), .bus(bus16.slave));

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a | b;
            3'd3: return a & b;
            3'd4: return a ^ b;
            3'd5: return ~(a | b);
            3'd6: return (sa < sb) ? 32'd1 : 32'd0;
            default: return (a < b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic void md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eh, output logic [31:0] el, output logic wr);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, pu, qu, ru;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        eh = '0;
        el = '0;
        wr = 1'b1;
        case (op)
            3'd1: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            3'd2: begin pu = ua * ub; eh = pu[63:32]; el = pu[31:0]; end
            3'd3: if (b == 0) wr = 1'b0; else begin q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0]; end
            default: if (b == 0) wr = 1'b0; else begin qu = ua / ub; ru = ua % ub; eh = ru[31:0]; el = qu[31:0]; end
        endcase
    endfunction

    // Entered and left at a falling edge; inject issues extra starts every busy cycle.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, input string name);
        logic [31:0] eh, el;
        logic        wr;
        int          n;
        md_ref(op, a, b, eh, el, wr);
        n = (op == 3'd1 || op == 3'd2) ? 5 : 10;
        bus32.MDop = op; bus32.A = a; bus32.B = b; bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0; bus32.MDop = 3'd0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            tests++;
            if (bus32.busy !== 1'b1) begin
                fails++; $display("FAIL %s busy c%0d: got %b want 1", name, i, bus32.busy);
            end
            tests++;
            if (bus32.done !== logic'(i == n)) begin
                fails++; $display("FAIL %s done c%0d: got %b want %b", name, i, bus32.done, i == n);
            end
            tests++;
            if (bus32.hi !== m_hi || bus32.lo !== m_lo) begin
                fails++; $display("FAIL %s early_hilo c%0d: got %h_%h want %h_%h", name, i, bus32.hi, bus32.lo, m_hi, m_lo);
            end
            if (inject) begin
                bus32.start = 1'b1;
                bus32.MDop  = (i % 3 == 0) ? 3'd5 : ((i % 3 == 1) ? 3'd6 : 3'd3);
                bus32.A     = (i % 3 == 1) ? 32'h1234 : $urandom;
                bus32.B     = $urandom_range(1, 100);
                @(posedge clk); #1;
                bus32.start = 1'b0; bus32.MDop = 3'd0;
            end
        end
        if (wr) begin m_hi = eh; m_lo = el; end
        @(negedge clk);
        tests++;
        if (bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin
            fails++; $display("FAIL %s end_flags: got busy=%b done=%b want 0 0", name, bus32.busy, bus32.done);
        end
        tests++;
        if (bus32.hi !== m_hi || bus32.lo !== m_lo) begin
            fails++; $display("FAIL %s result: got %h_%h want %h_%h", name, bus32.hi, bus32.lo, m_hi, m_lo);
        end
    endtask

    task automatic run_simple(input logic [2:0] op, input logic [31:0] a, input string name);
        bus32.MDop = op; bus32.A = a; bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0; bus32.MDop = 3'd0;
        if (op == 3'd5) m_hi = a;
        if (op == 3'd6) m_lo = a;
        tests++;
        if (bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin
            fails++; $display("FAIL %s flags: got busy=%b done=%b want 0 0", name, bus32.busy, bus32.done);
        end
        @(negedge clk);
        tests++;
        if (bus32.hi !== m_hi || bus32.lo !== m_lo) begin
            fails++; $display("FAIL %s hilo: got %h_%h want %h_%h", name, bus32.hi, bus32.lo, m_hi, m_lo);
        end
    endtask

    task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input string name);
        int sa, sb, p;
        int unsigned ua, ub, pu;
        int n;
        logic [15:0] eh, el;
        logic wr;
        sa = $signed(a); sb = $signed(b); ua = a; ub = b;
        wr = 1'b1; eh = '0; el = '0;
        case (op)
            3'd1: begin p = sa * sb; eh = p[31:16]; el = p[15:0]; end
            3'd2: begin pu = ua * ub; eh = pu[31:16]; el = pu[15:0]; end
            3'd3: if (b == 0) wr = 1'b0; else begin p = sa / sb; el = p[15:0]; p = sa % sb; eh = p[15:0]; end
            default: if (b == 0) wr = 1'b0; else begin pu = ua / ub; el = pu[15:0]; pu = ua % ub; eh = pu[15:0]; end
        endcase
        n = (op == 3'd1 || op == 3'd2) ? 1 : 16;
        bus16.MDop = op; bus16.A = a; bus16.B = b; bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0; bus16.MDop = 3'd0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            tests++;
            if (bus16.busy !== 1'b1 || bus16.done !== logic'(i == n)) begin
                fails++; $display("FAIL %s w16 flags c%0d: got busy=%b done=%b want 1 %b", name, i, bus16.busy, bus16.done, i == n);
            end
        end
        if (wr) begin m16_hi = eh; m16_lo = el; end
        @(negedge clk);
        tests++;
        if (bus16.busy !== 1'b0 || bus16.hi !== m16_hi || bus16.lo !== m16_lo) begin
            fails++; $display("FAIL %s w16 result: got busy=%b %h_%h want 0 %h_%h", name, bus16.busy, bus16.hi, bus16.lo, m16_hi, m16_lo);
        end
    endtask

    task automatic check_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
        bus32.ALUctr = op; bus32.A = a; bus32.B = b;
        #1;
        tests++;
        if (bus32.Output !== alu_ref(op, a, b)) begin
            fails++; $display("FAIL %s op%0d a=%h b=%h: got %h want %h", name, op, a, b, bus32.Output, alu_ref(op, a, b));
        end
        tests++;
        if (bus32.zero !== logic'(a == b)) begin
            fails++; $display("FAIL %s zero a=%h b=%h: got %b want %b", name, a, b, bus32.zero, a == b);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        m_hi = '0; m_lo = '0; m16_hi = '0; m16_lo = '0;
        tests++;
        if (bus32.busy !== 1'b0 || bus32.done !== 1'b0 || bus32.hi !== '0 || bus32.lo !== '0) begin
            fails++; $display("FAIL reset32: got busy=%b done=%b %h_%h want 0 0 0_0", bus32.busy, bus32.done, bus32.hi, bus32.lo);
        end
        tests++;
        if (bus16.busy !== 1'b0 || bus16.done !== 1'b0 || bus16.hi !== '0 || bus16.lo !== '0) begin
            fails++; $display("FAIL reset16: got busy=%b done=%b %h_%h want 0 0 0_0", bus16.busy, bus16.done, bus16.hi, bus16.lo);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu();
        check_alu(3'd0, 32'h7FFF_FFFF, 32'd1, "addu_wrap");
        check_alu(3'd6, 32'hFFFF_FFFF, 32'd1, "slt_neg");
        check_alu(3'd7, 32'hFFFF_FFFF, 32'd1, "sltu_big");
        check_alu(3'd1, 32'd0, 32'd1, "subu_wrap");
        check_alu(3'd4, 32'd5, 32'd5, "zero_eq");
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            check_alu(3'($urandom_range(0, 7)), a, b, "alu_rand");
        end
    endtask

    task automatic test_alu_while_busy();
        logic [31:0] eh, el;
        logic wr;
        @(negedge clk);
        md_ref(3'd4, 32'd100, 32'd7, eh, el, wr);
        bus32.MDop = 3'd4; bus32.A = 32'd100; bus32.B = 32'd7; bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0; bus32.MDop = 3'd0;
        tests++;
        if (bus32.busy !== 1'b1) begin
            fails++; $display("FAIL alu_busy busy: got %b want 1", bus32.busy);
        end
        for (int i = 0; i < 8; i++) check_alu(3'($urandom_range(0, 7)), $urandom, $urandom, "alu_busy");
        repeat (12) @(negedge clk);
        m_hi = eh; m_lo = el;
        tests++;
        if (bus32.busy !== 1'b0 || bus32.hi !== m_hi || bus32.lo !== m_lo) begin
            fails++; $display("FAIL alu_busy divu: got busy=%b %h_%h want 0 %h_%h", bus32.busy, bus32.hi, bus32.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_mult();
        run_md(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult");
        tests++;
        if (bus32.hi !== 32'hFFFF_FFFF || bus32.lo !== 32'hFFFF_FFFA) begin
            fails++; $display("FAIL mult_const: got %h_%h want ffffffff_fffffffa", bus32.hi, bus32.lo);
        end
        run_md(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, "multu");
        tests++;
        if (bus32.hi !== 32'h0000_0002 || bus32.lo !== 32'hFFFF_FFFA) begin
            fails++; $display("FAIL multu_const: got %h_%h want 00000002_fffffffa", bus32.hi, bus32.lo);
        end
    endtask

    task automatic test_div();
        run_md(3'd3, -32'sd7, 32'd2, 1'b0, "div");
        tests++;
        if (bus32.hi !== 32'hFFFF_FFFF || bus32.lo !== 32'hFFFF_FFFD) begin
            fails++; $display("FAIL div_const: got %h_%h want ffffffff_fffffffd", bus32.hi, bus32.lo);
        end
        run_md(3'd4, 32'd7, 32'd0, 1'b0, "divu_by0");
        run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_minneg");
        run_md(3'd3, 32'd9, 32'd0, 1'b0, "div_by0");
    endtask

    task automatic test_mthi_mtlo();
        run_simple(3'd5, 32'hDEAD_BEEF, "mthi");
        run_simple(3'd6, 32'hCAFE_F00D, "mtlo");
        run_simple(3'd0, 32'h1111_1111, "none");
        run_simple(3'd7, 32'h2222_2222, "reserved");
    endtask

    task automatic test_overlap();
        run_md(3'd1, 32'h0001_0003, 32'hFFFF_0007, 1'b1, "overlap_mult");
        run_md(3'd3, $urandom, 32'd13, 1'b1, "overlap_div");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 9);
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            if (op >= 3'd1 && op <= 3'd4) run_md(op, a, b, 1'b0, "rand_md");
            else run_simple(op, a, "rand_simple");
        end
    endtask

    task automatic test_reset_abort();
        run_simple(3'd5, 32'h5555_AAAA, "pre_abort");
        bus32.MDop = 3'd1; bus32.A = 32'd1000; bus32.B = 32'd1000; bus32.start = 1'b1;
        @(posedge clk); #1;
        bus32.start = 1'b0; bus32.MDop = 3'd0;
        @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        m_hi = '0; m_lo = '0; m16_hi = '0; m16_lo = '0;
        tests++;
        if (bus32.busy !== 1'b0 || bus32.done !== 1'b0 || bus32.hi !== '0 || bus32.lo !== '0) begin
            fails++; $display("FAIL abort_async: got busy=%b done=%b %h_%h want 0 0 0_0", bus32.busy, bus32.done, bus32.hi, bus32.lo);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_md(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, "after_reset");
    endtask

    task automatic test_param_sweep();
        run16(3'd1, 16'hFFFE, 16'd3, "mult16");
        run16(3'd3, 16'h8000, 16'hFFFF, "div16_minneg");
        tests++;
        if (bus16.lo !== 16'h8000 || bus16.hi !== 16'h0000) begin
            fails++; $display("FAIL div16_const: got %h_%h want 0000_8000", bus16.hi, bus16.lo);
        end
        for (int i = 0; i < 6; i++) begin
            run16(3'($urandom_range(1, 4)), 16'($urandom), 16'($urandom_range(0, 300)), "rand16");
        end
    endtask

    initial begin
        reset = 1'b1;
        bus32.A = '0; bus32.B = '0; bus32.ALUctr = '0; bus32.MDop = '0; bus32.start = 1'b0;
        bus16.A = '0; bus16.B = '0; bus16.ALUctr = '0; bus16.MDop = '0; bus16.start = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_alu();
        test_alu_while_busy();
        @(negedge clk);
        test_mthi_mtlo();
        test_overlap();
        test_back_to_back();
        test_reset_abort();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
